dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_rvalid,
   output logic [31:0]           cpu_rdata,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [31:0]           mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [31:0]           mem_wdata,
   output logic                  mem_wen
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses
`endif
);

   localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;
   localparam int LINES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [31:0]             data_q [LINES];
   logic                    cpu_rvalid_q, cpu_rvalid_d;
   logic [31:0]             cpu_rdata_q, cpu_rdata_d;
   logic [ADDR_WIDTH-1:0]   mem_raddr_q, mem_raddr_d;
   logic [ADDR_WIDTH-1:0]   mem_waddr_q, mem_waddr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;
   logic                    mem_wen_q, mem_wen_d;

   logic [INDEX_BITS-1:0]   idx_s;
   logic [TAG_W-1:0]        tag_s;
   logic                    hit_s;
   logic                    accept_s;
   logic                    line_we_s;
   logic [INDEX_BITS-1:0]   line_idx_s;
   logic [TAG_W-1:0]        line_tag_s;
   logic [31:0]             line_data_s;

   assign idx_s    = cpu_addr[INDEX_BITS-1:0];
   assign tag_s    = cpu_addr[ADDR_WIDTH-1:INDEX_BITS];
   assign hit_s    = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
   assign accept_s = cpu_req && (state_q == IDLE);

   // Next-state, line update and registered output computation.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      cpu_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      mem_raddr_d  = mem_raddr_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wen_d    = 1'b0;
      line_we_s    = 1'b0;
      line_idx_s   = idx_s;
      line_tag_s   = tag_s;
      line_data_s  = cpu_wdata;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (cpu_we) begin
                  mem_waddr_d = cpu_addr;
                  mem_wdata_d = cpu_wdata;
                  mem_wen_d   = 1'b1;
                  state_d     = WRITE;
                  // Write-through: refresh the cached copy only on a hit.
                  if (hit_s) begin
                     line_we_s = 1'b1;
                  end else begin
                     line_we_s = 1'b0;
                  end
               end else if (hit_s) begin
                  cpu_rdata_d  = data_q[idx_s];
                  cpu_rvalid_d = 1'b1;
               end else begin
                  mem_raddr_d = cpu_addr;
                  state_d     = FILL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         FILL: begin
            // The pending line's index and tag live in the read address register.
            line_we_s           = 1'b1;
            line_idx_s          = mem_raddr_q[INDEX_BITS-1:0];
            line_tag_s          = mem_raddr_q[ADDR_WIDTH-1:INDEX_BITS];
            line_data_s         = mem_rdata;
            valid_d[line_idx_s] = 1'b1;
            cpu_rdata_d         = mem_rdata;
            cpu_rvalid_d        = 1'b1;
            state_d             = IDLE;
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, valid bits and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= 32'd0;
         mem_raddr_q  <= '0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= 32'd0;
         mem_wen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         mem_raddr_q  <= mem_raddr_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wen_q    <= mem_wen_d;
      end
   end

   // Tag and data arrays are left unreset; the valid bits gate every hit.
   always_ff @(posedge clk) begin
      if (line_we_s) begin
         tag_q[line_idx_s]  <= line_tag_s;
         data_q[line_idx_s] <= line_data_s;
      end
   end

   assign cpu_ready  = (state_q == IDLE);
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign mem_raddr  = mem_raddr_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wen    = mem_wen_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   // Only accepted loads are counted; counters wrap naturally.
   always_comb begin
      stat_hits_d   = stat_hits_q;
      stat_misses_d = stat_misses_q;
      if (accept_s && !cpu_we) begin
         if (hit_s) begin
            stat_hits_d = stat_hits_q + 32'd1;
         end else begin
            stat_misses_d = stat_misses_q + 32'd1;
         end
      end else begin
         stat_hits_d = stat_hits_q;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits_q   <= 32'd0;
         stat_misses_q <= 32'd0;
      end else begin
         stat_hits_q   <= stat_hits_d;
         stat_misses_q <= stat_misses_d;
      end
   end

   assign stat_hits   = stat_hits_q;
   assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a falling-edge word memory model.
module tb_dcache_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic        cpu_ready;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wen;
`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   logic [31:0] mem [256];
   logic        bd_we = 1'b0;
   logic [7:0]  bd_addr = 8'd0;
   logic [31:0] bd_data = 32'd0;
   int checks = 0;
   int errors = 0;
   int rv_cnt = 0;
   int wen_cnt = 0;

   dcache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_wen(mem_wen)
`ifdef DCACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;

   // Memory: commits writes, then presents read data, on the falling edge.
   always @(negedge clk) begin
      if (bd_we) mem[bd_addr] = bd_data;
      if (mem_wen) mem[mem_waddr[7:0]] = mem_wdata;
      mem_rdata = mem[mem_raddr[7:0]];
      if (cpu_rvalid) rv_cnt++;
      if (mem_wen) wen_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      @(negedge clk);
      #1;
      bd_we   = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", cpu_rvalid); end
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
      checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", mem_wen); end
      checks++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'd0) begin errors++; $display("FAIL reset_mem_port: got %h/%h/%h expected 0", mem_raddr, mem_waddr, mem_wdata); end
`ifdef DCACHE_STATS_EN
      checks++; if ({stat_hits, stat_misses} !== 64'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_hits, stat_misses); end
`endif
      poke(8'h05, 32'hDEADBEEF);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_cold_load();
      int w0, r0;
      w0 = wen_cnt; r0 = rv_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h05;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL cold_ready_pre: got %b expected 1", cpu_ready); end
      tick();
      cpu_req = 1'b0; cpu_addr = 32'h3C;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL cold_ready_fill: got %b expected 0", cpu_ready); end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cold_rvalid_early: got %b expected 0", cpu_rvalid); end
      checks++; if (mem_raddr !== 32'h05) begin errors++; $display("FAIL cold_raddr: got %h expected 05", mem_raddr); end
      tick();
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cold_rvalid: got %b expected 1", cpu_rvalid); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rdata: got %h expected deadbeef", cpu_rdata); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL cold_ready_post: got %b expected 1", cpu_ready); end
      tick();
      checks++; if (rv_cnt - r0 !== 1) begin errors++; $display("FAIL cold_rvalid_pulses: got %0d expected 1", rv_cnt - r0); end
      checks++; if (wen_cnt !== w0) begin errors++; $display("FAIL cold_no_wen: got %0d expected %0d", wen_cnt, w0); end
   endtask

   task automatic test_hit();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h05;
      tick();
      cpu_req = 1'b0;
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL hit_rvalid: got %b expected 1", cpu_rvalid); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_rdata: got %h expected deadbeef", cpu_rdata); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL hit_ready: got %b expected 1", cpu_ready); end
      checks++; if (mem_raddr !== 32'h05) begin errors++; $display("FAIL hit_raddr: got %h expected 05", mem_raddr); end
      tick();
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL hit_rvalid_drop: got %b expected 0", cpu_rvalid); end
   endtask

   task automatic test_store_hit();
      int w0;
      w0 = wen_cnt;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h05; cpu_wdata = 32'h12345678;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'hFFFFFFFF;
      checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL sthit_wen: got %b expected 1", mem_wen); end
      checks++; if (mem_waddr !== 32'h05) begin errors++; $display("FAIL sthit_waddr: got %h expected 05", mem_waddr); end
      checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL sthit_wdata: got %h expected 12345678", mem_wdata); end
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL sthit_ready: got %b expected 0", cpu_ready); end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL sthit_rvalid: got %b expected 0", cpu_rvalid); end
      tick();
      checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL sthit_wen_drop: got %b expected 0", mem_wen); end
      checks++; if (mem[5] !== 32'h12345678) begin errors++; $display("FAIL sthit_memory: got %h expected 12345678", mem[5]); end
      checks++; if (wen_cnt - w0 !== 1) begin errors++; $display("FAIL sthit_wen_cycles: got %0d expected 1", wen_cnt - w0); end
      cpu_req = 1'b1; cpu_addr = 32'h05;
      tick();
      cpu_req = 1'b0;
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL sthit_load_rvalid: got %b expected 1", cpu_rvalid); end
      checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL sthit_load_rdata: got %h expected 12345678", cpu_rdata); end
      tick();
   endtask

   task automatic test_store_miss_conflict();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h15; cpu_wdata = 32'hA5A5A5A5;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      checks++; if (mem_waddr !== 32'h15) begin errors++; $display("FAIL stmiss_waddr: got %h expected 15", mem_waddr); end
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h15;
      tick();
      cpu_req = 1'b0;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL stmiss_load_is_miss: got ready %b expected 0", cpu_ready); end
      tick();
      checks++; if (cpu_rdata !== 32'hA5A5A5A5 || cpu_rvalid !== 1'b1) begin errors++; $display("FAIL stmiss_load_rdata: got %h/%b expected a5a5a5a5/1", cpu_rdata, cpu_rvalid); end
      cpu_req = 1'b1; cpu_addr = 32'h05;
      tick();
      cpu_req = 1'b0;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL conflict_evicted: got ready %b expected 0", cpu_ready); end
      tick();
      checks++; if (cpu_rdata !== 32'h12345678 || cpu_rvalid !== 1'b1) begin errors++; $display("FAIL conflict_rdata: got %h/%b expected 12345678/1", cpu_rdata, cpu_rvalid); end
`ifdef DCACHE_STATS_EN
      checks++; if (stat_hits !== 32'd2 || stat_misses !== 32'd3) begin errors++; $display("FAIL stats: got %0d/%0d expected 2/3", stat_hits, stat_misses); end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = rv_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h05;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (cpu_rvalid !== 1'b1 || cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_%0d: got rvalid %b ready %b expected 1 1", i, cpu_rvalid, cpu_ready); end
      end
      cpu_req = 1'b0;
      tick();
      checks++; if (rv_cnt - r0 !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", rv_cnt - r0); end
   endtask

   task automatic test_reset_mid_fill();
      int r0;
      poke(8'h07, 32'h77777777);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h07;
      tick();
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rstfill_in_fill: got ready %b expected 0", cpu_ready); end
      rst_n = 1'b0; cpu_req = 1'b0;
      #1;
      r0 = rv_cnt;
      checks++; if (cpu_rdata !== 32'd0 || mem_raddr !== 32'd0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstfill_zero: got %h/%h/%b expected 0/0/0", cpu_rdata, mem_raddr, cpu_rvalid); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rstfill_ready: got %b expected 1", cpu_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (rv_cnt !== r0) begin errors++; $display("FAIL rstfill_no_rvalid: got %0d expected %0d", rv_cnt, r0); end
      cpu_req = 1'b1; cpu_addr = 32'h05;
      tick();
      cpu_req = 1'b0;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rstfill_valid_cleared: got ready %b expected 0", cpu_ready); end
      tick();
      checks++; if (cpu_rdata !== 32'h12345678 || cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rstfill_reload: got %h/%b expected 12345678/1", cpu_rdata, cpu_rvalid); end
      tick();
   endtask

   task automatic test_reset_mid_write();
      int w0;
      poke(8'h09, 32'h99990000);
      w0 = wen_cnt;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h09; cpu_wdata = 32'h11112222;
      tick();
      checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL rstwr_wen: got %b expected 1", mem_wen); end
      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      checks++; if (mem_wen !== 1'b0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rstwr_zero: got %b/%h expected 0/0", mem_wen, mem_wdata); end
      tick();
      tick();
      rst_n = 1'b1;
      checks++; if (mem[9] !== 32'h99990000) begin errors++; $display("FAIL rstwr_dropped: got %h expected 99990000", mem[9]); end
      checks++; if (wen_cnt !== w0) begin errors++; $display("FAIL rstwr_wen_cycles: got %0d expected %0d", wen_cnt, w0); end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_hit();
      test_store_hit();
      test_store_miss_conflict();
      test_back_to_back();
      test_reset_mid_fill();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
